loop_apu_sequencer: RTL and testbench

- Parametrised successor to the program control unit.
- Walks one program from start_pc to end_pc and retires loop instructions internally using a configurable-depth loop stack.
- Keeps APU_CNT address registers as base plus the sum over loop depths of coefficient times iteration index.
- Emits load/store, RAM and arithmetic instructions to the instruction queue over a valid/ready handshake with backpressure.
- Emits up to SUPERSCALAR_WIDTH lanes per instruction for independent loops, plus a per-lane address stride.

---
 rtl/loop_apu_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_loop_apu_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_apu_sequencer.sv
// Loop-aware APU sequencer: walks a program from start_pc to end_pc.
// Loop instructions are retired internally on a loop stack.
// Memory and arithmetic instructions go out to the instruction queue,
// together with their APU-generated addresses, lane strides and lane counts.
module loop_apu_sequencer #(
    parameter int LOG_SUPERSCALAR_WIDTH = 3,
    parameter int LOG_LOOP_DEPTH        = 3,
    parameter int LOG_APU_CNT           = 3,
    parameter int ADDR_W                = 18
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [15:0]                      start_pc,
    input  logic [15:0]                      end_pc,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    input  logic                             cfg_we,
    input  logic [LOG_APU_CNT-1:0]           cfg_apu,
    input  logic [LOG_LOOP_DEPTH:0]          cfg_sel,
    input  logic [ADDR_W-1:0]                cfg_data,
    output logic [15:0]                      pc,
    input  logic [15:0]                      raw_instruction,
    output logic                             q_valid,
    input  logic                             q_ready,
    output logic [1:0]                       q_type,
    output logic [13:0]                      q_instr,
    output logic [ADDR_W-1:0]                q_cache_addr,
    output logic [ADDR_W-1:0]                q_main_addr,
    output logic [ADDR_W-1:0]                q_d_cache_addr,
    output logic [ADDR_W-1:0]                q_d_main_addr,
    output logic [LOG_SUPERSCALAR_WIDTH:0]   q_copies
);
    localparam int W       = 1 << LOG_SUPERSCALAR_WIDTH;
    localparam int D       = 1 << LOG_LOOP_DEPTH;
    localparam int APU_CNT = 1 << LOG_APU_CNT;
    localparam int SW      = LOG_SUPERSCALAR_WIDTH + 1;
    localparam int DW      = LOG_LOOP_DEPTH + 1;

    typedef enum logic [2:0] {IDLE, DECODE, LOOP_UPDATE, EMIT, DONE} state_t;

    typedef struct packed {
        logic [11:0]   i;     // iteration index of the current pass
        logic [11:0]   n;     // iteration count
        logic [SW-1:0] step;  // lanes covered by the current pass
        logic          ind;   // independent loop: iterations fan out as lanes
    } frame_t;

    state_t                                     state;
    logic [APU_CNT-1:0][ADDR_W-1:0]             a_reg;
    logic [APU_CNT-1:0][ADDR_W-1:0]             base_reg;
    logic [APU_CNT-1:0][D-1:0][ADDR_W-1:0]      coef;
    frame_t                                     stack [D];
    logic [DW-1:0]                              sp;

    // Instruction fields
    logic [1:0]             ty;
    logic                   f_ind, f_start;
    logic [11:0]            f_n;
    logic [7:0]             f_j;
    logic [LOG_APU_CNT-1:0] apu_c, apu_m;
    assign ty      = raw_instruction[15:14];
    assign f_ind   = raw_instruction[13];
    assign f_start = raw_instruction[12];
    assign f_n     = raw_instruction[11:0];
    assign f_j     = raw_instruction[7:0];
    assign apu_c   = raw_instruction[3 +: LOG_APU_CNT];
    assign apu_m   = raw_instruction[0 +: LOG_APU_CNT];

    // Top-of-stack view
    logic                      empty, full;
    logic [LOG_LOOP_DEPTH-1:0] t;
    frame_t                    top;
    logic [12:0]               i_next;
    logic                      cont;
    assign empty  = (sp == '0);
    assign full   = (sp == DW'(D));
    assign t      = LOG_LOOP_DEPTH'(sp - 1'b1);
    assign top    = stack[t];
    assign i_next = {1'b0, top.i} + 13'(top.step);
    assign cont   = i_next < {1'b0, top.n};

    assign busy = (state != IDLE);

    // Lane count for an independent loop pass: remaining iterations, capped at W
    function automatic logic [SW-1:0] clamp_step(input logic [11:0] rem);
        if (int'(rem) >= W) return SW'(W);
        return SW'(rem);
    endfunction

    logic [SW-1:0] step_next;
    assign step_next = top.ind ? clamp_step(top.n - i_next[11:0]) : SW'(1);

    // Per-lane strides come from the innermost open loop's coefficients
    logic [ADDR_W-1:0] stride_c, stride_m;
    always_comb begin
        stride_c = '0;
        stride_m = '0;
        if (!empty) begin
            stride_c = coef[apu_c][t];
            stride_m = coef[apu_m][t];
        end
    end

    // Sequencer FSM with APU register file, loop stack and queue outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pc             <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            sp             <= '0;
            a_reg          <= '0;
            base_reg       <= '0;
            coef           <= '0;
            q_valid        <= 1'b0;
            q_type         <= '0;
            q_instr        <= '0;
            q_cache_addr   <= '0;
            q_main_addr    <= '0;
            q_d_cache_addr <= '0;
            q_d_main_addr  <= '0;
            q_copies       <= '0;
            for (int d = 0; d < D; d++) stack[d] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= start_pc;
                        a_reg <= base_reg;
                        sp    <= '0;
                        err   <= 1'b0;
                        state <= DECODE;
                    end else if (cfg_we) begin
                        if (cfg_sel == DW'(D))
                            base_reg[cfg_apu] <= cfg_data;
                        else if (cfg_sel < DW'(D))
                            coef[cfg_apu][cfg_sel[LOG_LOOP_DEPTH-1:0]] <= cfg_data;
                    end
                end
                DECODE: begin
                    if (ty == 2'b11) begin
                        if (f_start) begin
                            if (f_n == '0 || full) begin
                                err   <= 1'b1;
                                state <= DONE;
                            end else begin
                                stack[sp[LOG_LOOP_DEPTH-1:0]] <= '{i: '0, n: f_n,
                                    step: f_ind ? clamp_step(f_n) : SW'(1), ind: f_ind};
                                sp    <= sp + 1'b1;
                                state <= (pc == end_pc) ? DONE : DECODE;
                                if (pc != end_pc) pc <= pc + 16'd1;
                            end
                        end else if (empty || f_j == '0) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= LOOP_UPDATE;
                        end
                    end else begin
                        q_type         <= ty;
                        q_instr        <= raw_instruction[13:0];
                        q_copies       <= empty ? SW'(1) : top.step;
                        q_cache_addr   <= '0;
                        q_main_addr    <= '0;
                        q_d_cache_addr <= '0;
                        q_d_main_addr  <= '0;
                        if (ty == 2'b00) begin
                            q_cache_addr   <= a_reg[apu_m];
                            q_d_cache_addr <= stride_m;
                        end else if (ty == 2'b01) begin
                            q_cache_addr   <= a_reg[apu_c];
                            q_d_cache_addr <= stride_c;
                            q_main_addr    <= a_reg[apu_m];
                            q_d_main_addr  <= stride_m;
                        end
                        q_valid <= 1'b1;
                        state   <= EMIT;
                    end
                end
                LOOP_UPDATE: begin
                    if (cont) begin
                        for (int k = 0; k < APU_CNT; k++)
                            a_reg[k] <= a_reg[k] + ADDR_W'(top.step) * coef[k][t];
                        stack[t].i    <= i_next[11:0];
                        stack[t].step <= step_next;
                        pc            <= pc - 16'(f_j);
                        state         <= DECODE;
                    end else begin
                        // Undo the whole loop's contribution so the APUs see the pre-loop value
                        for (int k = 0; k < APU_CNT; k++)
                            a_reg[k] <= a_reg[k] - ADDR_W'(top.i) * coef[k][t];
                        sp    <= sp - 1'b1;
                        state <= (pc == end_pc) ? DONE : DECODE;
                        if (pc != end_pc) pc <= pc + 16'd1;
                    end
                end
                EMIT: begin
                    if (q_ready) begin
                        q_valid <= 1'b0;
                        state   <= (pc == end_pc) ? DONE : DECODE;
                        if (pc != end_pc) pc <= pc + 16'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_loop_apu_sequencer.sv
// Directed bench for loop_apu_sequencer: loop walking, APU address generation,
// backpressure, error paths and reset abort.
module tb_loop_apu_sequencer;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic reset, start, start2, cfg_we, q_ready;
    logic [15:0] start_pc, end_pc;
    logic [2:0] cfg_apu;
    logic [3:0] cfg_sel;
    logic [AW-1:0] cfg_data;

    logic busy, done, err, q_valid;
    logic [15:0] pc, raw_instruction;
    logic [1:0] q_type;
    logic [13:0] q_instr;
    logic [AW-1:0] q_cache_addr, q_main_addr, q_d_cache_addr, q_d_main_addr;
    logic [3:0] q_copies;

    logic busy2, done2, err2, q_valid2;
    logic [15:0] pc2, raw2;
    logic [1:0] q_type2;
    logic [13:0] q_instr2;
    logic [AW-1:0] q_cache2, q_main2, q_dcache2, q_dmain2;
    logic [3:0] q_copies2;

    logic [15:0] imem [16];
    assign raw_instruction = imem[pc[3:0]];
    assign raw2            = imem[pc2[3:0]];

    int checks = 0;
    int errors = 0;
    int r_cache[$], r_dc[$], r_main[$], r_cp[$], r_ty[$];
    bit got_done;

    loop_apu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .end_pc(end_pc),
        .busy(busy), .done(done), .err(err), .cfg_we(cfg_we), .cfg_apu(cfg_apu),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .pc(pc), .raw_instruction(raw_instruction),
        .q_valid(q_valid), .q_ready(q_ready), .q_type(q_type), .q_instr(q_instr),
        .q_cache_addr(q_cache_addr), .q_main_addr(q_main_addr),
        .q_d_cache_addr(q_d_cache_addr), .q_d_main_addr(q_d_main_addr), .q_copies(q_copies));

    loop_apu_sequencer #(.LOG_LOOP_DEPTH(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .start_pc(start_pc), .end_pc(end_pc),
        .busy(busy2), .done(done2), .err(err2), .cfg_we(cfg_we), .cfg_apu(cfg_apu),
        .cfg_sel(cfg_sel[1:0]), .cfg_data(cfg_data), .pc(pc2), .raw_instruction(raw2),
        .q_valid(q_valid2), .q_ready(q_ready), .q_type(q_type2), .q_instr(q_instr2),
        .q_cache_addr(q_cache2), .q_main_addr(q_main2),
        .q_d_cache_addr(q_dcache2), .q_d_main_addr(q_dmain2), .q_copies(q_copies2));

    always #5 clk = ~clk;

    function automatic logic [15:0] i_start(input logic ind, input int n);
        return {2'b11, ind, 1'b1, 12'(n)};
    endfunction
    function automatic logic [15:0] i_end(input int j);
        return {4'b1100, 4'b0000, 8'(j)};
    endfunction
    function automatic logic [15:0] i_ldst(input int a);
        return {2'b00, 11'b0, 3'(a)};
    endfunction
    function automatic logic [15:0] i_ram(input int c, input int m);
        return {2'b01, 8'b0, 3'(c), 3'(m)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int apu, input int sel, input int data);
        cfg_we = 1'b1; cfg_apu = 3'(apu); cfg_sel = 4'(sel); cfg_data = AW'(data);
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic clear_imem;
        for (int a = 0; a < 16; a++) imem[a] = 16'h8000;
    endtask

    // Start the main DUT and collect every accepted queue entry until done
    task automatic run_prog(input logic [15:0] s, input logic [15:0] e);
        r_cache.delete(); r_dc.delete(); r_main.delete(); r_cp.delete(); r_ty.delete();
        got_done = 0;
        start_pc = s; end_pc = e; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (q_valid && q_ready) begin
                r_cache.push_back(int'(q_cache_addr)); r_dc.push_back(int'(q_d_cache_addr));
                r_main.push_back(int'(q_main_addr)); r_cp.push_back(int'(q_copies));
                r_ty.push_back(int'(q_type));
            end
            if (done) begin got_done = 1; break; end
            tick;
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL run_done: got no done pulse, required one within 300 cycles");
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 0; start2 = 0; cfg_we = 0; q_ready = 1'b1;
        cfg_apu = 0; cfg_sel = 0; cfg_data = 0; start_pc = 0; end_pc = 0;
        tick; tick;
        reset = 1'b0;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rst_qvalid: got %b want 0", q_valid); end
        checks++; if (pc !== 16'd0)     begin errors++; $display("FAIL rst_pc: got %0d want 0", pc); end
        checks++; if (q_copies !== 4'd0) begin errors++; $display("FAIL rst_copies: got %0d want 0", q_copies); end
    endtask

    task automatic test_dependent;
        int ec[4] = '{100, 104, 108, 100};
        int ed[4] = '{4, 4, 4, 0};
        clear_imem;
        imem[0] = i_start(0, 3); imem[1] = i_ldst(0); imem[2] = i_end(1); imem[3] = i_ldst(0);
        cfg(0, 0, 4); cfg(0, 8, 100);
        run_prog(0, 3);
        checks++; if (r_cache.size() != 4) begin errors++; $display("FAIL dep_count: got %0d want 4", r_cache.size()); end
        for (int k = 0; k < 4 && k < r_cache.size(); k++) begin
            checks++; if (r_cache[k] != ec[k]) begin errors++; $display("FAIL dep_cache[%0d]: got %0d want %0d", k, r_cache[k], ec[k]); end
            checks++; if (r_dc[k] != ed[k])    begin errors++; $display("FAIL dep_dcache[%0d]: got %0d want %0d", k, r_dc[k], ed[k]); end
            checks++; if (r_cp[k] != 1)        begin errors++; $display("FAIL dep_copies[%0d]: got %0d want 1", k, r_cp[k]); end
            checks++; if (r_main[k] != 0 || r_ty[k] != 0) begin errors++; $display("FAIL dep_main_type[%0d]: got %0d/%0d want 0/0", k, r_main[k], r_ty[k]); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL dep_err: got %b want 0", err); end
    endtask

    task automatic test_independent;
        int ec[3] = '{100, 132, 100};
        int ed[3] = '{4, 4, 0};
        int ep[3] = '{8, 2, 1};
        imem[0] = i_start(1, 10);
        run_prog(0, 3);
        checks++; if (r_cache.size() != 3) begin errors++; $display("FAIL ind_count: got %0d want 3", r_cache.size()); end
        for (int k = 0; k < 3 && k < r_cache.size(); k++) begin
            checks++; if (r_cache[k] != ec[k]) begin errors++; $display("FAIL ind_cache[%0d]: got %0d want %0d", k, r_cache[k], ec[k]); end
            checks++; if (r_dc[k] != ed[k])    begin errors++; $display("FAIL ind_dcache[%0d]: got %0d want %0d", k, r_dc[k], ed[k]); end
            checks++; if (r_cp[k] != ep[k])    begin errors++; $display("FAIL ind_copies[%0d]: got %0d want %0d", k, r_cp[k], ep[k]); end
        end
    endtask

    task automatic test_nested;
        int ec[4] = '{100, 104, 164, 168};
        clear_imem;
        imem[0] = i_start(0, 2); imem[1] = i_start(0, 2); imem[2] = i_ram(0, 1);
        imem[3] = i_end(1); imem[4] = i_end(3);
        cfg(0, 0, 64); cfg(0, 1, 4);
        run_prog(0, 4);
        checks++; if (r_cache.size() != 4) begin errors++; $display("FAIL nest_count: got %0d want 4", r_cache.size()); end
        for (int k = 0; k < 4 && k < r_cache.size(); k++) begin
            checks++; if (r_cache[k] != ec[k]) begin errors++; $display("FAIL nest_cache[%0d]: got %0d want %0d", k, r_cache[k], ec[k]); end
            checks++; if (r_dc[k] != 4)        begin errors++; $display("FAIL nest_dcache[%0d]: got %0d want 4", k, r_dc[k]); end
            checks++; if (r_ty[k] != 1 || r_main[k] != 0) begin errors++; $display("FAIL nest_type_main[%0d]: got %0d/%0d want 1/0", k, r_ty[k], r_main[k]); end
        end
    endtask

    task automatic test_backpressure;
        int seen, hs;
        clear_imem;
        imem[0] = i_ldst(0);
        q_ready = 1'b0; start_pc = 0; end_pc = 0; start = 1'b1;
        tick;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (q_valid) seen = 1; else tick;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_valid: got no q_valid within 20 cycles, required one"); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (q_valid !== 1'b1 || pc !== 16'd0 || q_cache_addr !== AW'(100) || q_d_cache_addr !== '0
                || q_copies !== 4'd1 || q_type !== 2'd0 || q_instr !== 14'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b pc=%0d addr=%0d d=%0d cp=%0d ty=%0d want v=1 pc=0 addr=100 d=0 cp=1 ty=0",
                         c, q_valid, pc, q_cache_addr, q_d_cache_addr, q_copies, q_type);
            end
            tick;
        end
        q_ready = 1'b1;
        hs = 0;
        got_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (q_valid && q_ready) hs++;
            if (done) begin got_done = 1; break; end
            tick;
        end
        checks++; if (hs != 1 || !got_done) begin errors++; $display("FAIL bp_release: got %0d entries done=%0b want 1 entry done=1", hs, got_done); end
    endtask

    task automatic test_errors;
        clear_imem;
        imem[0] = i_end(1);
        run_prog(0, 2);
        checks++; if (err !== 1'b1)        begin errors++; $display("FAIL err_empty_end: got %b want 1", err); end
        checks++; if (r_cache.size() != 0) begin errors++; $display("FAIL err_empty_entries: got %0d want 0", r_cache.size()); end
        imem[0] = i_start(0, 0);
        run_prog(0, 2);
        checks++; if (err !== 1'b1)        begin errors++; $display("FAIL err_zero_n: got %b want 1", err); end
        // new start clears err; coef0[0] is now 64
        imem[0] = i_start(0, 3); imem[1] = i_ldst(0); imem[2] = i_end(1); imem[3] = i_ldst(0);
        start_pc = 0; end_pc = 3; start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
        run_prog(0, 3);
        checks++; if (r_cache.size() != 4 || r_cache[1] != 164) begin errors++; $display("FAIL err_rerun: got %0d entries want 4 with entry1=164", r_cache.size()); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_rerun_err: got %b want 0", err); end
    endtask

    task automatic test_depth_overflow;
        int saw_v, saw_d;
        clear_imem;
        imem[0] = i_start(0, 2); imem[1] = i_start(0, 2); imem[2] = i_start(0, 2); imem[3] = i_ldst(0);
        start_pc = 0; end_pc = 5; start2 = 1'b1;
        tick;
        start2 = 1'b0;
        saw_v = 0; saw_d = 0;
        for (int c = 0; c < 50; c++) begin
            if (q_valid2) saw_v = 1;
            if (done2) begin saw_d = 1; break; end
            tick;
        end
        checks++; if (!saw_d)        begin errors++; $display("FAIL ovf_done: got no done pulse, required one"); end
        checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", err2); end
        checks++; if (saw_v != 0)    begin errors++; $display("FAIL ovf_emit: got q_valid, required none"); end
    endtask

    task automatic test_reset_mid;
        int seen;
        int ec[4] = '{7, 10, 13, 7};
        clear_imem;
        imem[0] = i_start(0, 3); imem[1] = i_ldst(0); imem[2] = i_end(1); imem[3] = i_ldst(0);
        q_ready = 1'b0; start_pc = 0; end_pc = 3; start = 1'b1;
        tick;
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (q_valid) seen = 1; else tick;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rmid_valid: got no q_valid, required one"); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (q_valid !== 1'b0 || busy !== 1'b0 || pc !== 16'd0) begin
            errors++; $display("FAIL rmid_abort: got v=%b busy=%b pc=%0d want 0/0/0", q_valid, busy, pc);
        end
        q_ready = 1'b1;
        cfg(0, 8, 7); cfg(0, 0, 3);
        run_prog(0, 3);
        checks++; if (r_cache.size() != 4) begin errors++; $display("FAIL rmid_count: got %0d want 4", r_cache.size()); end
        for (int k = 0; k < 4 && k < r_cache.size(); k++) begin
            checks++; if (r_cache[k] != ec[k]) begin errors++; $display("FAIL rmid_cache[%0d]: got %0d want %0d", k, r_cache[k], ec[k]); end
        end
    endtask

    initial begin
        clear_imem;
        test_reset;
        test_dependent;
        test_independent;
        test_nested;
        test_backpressure;
        test_errors;
        test_depth_overflow;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
